// File: rtl/dcache_wb_pkg.sv
// Shared types, widths and address-split helpers for the write-back data cache.
package dcache_wb_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned DEF_LINES      = 4;
    localparam int unsigned DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVICT  = 2'd1,
        ST_FILL   = 2'd2,
        ST_REPLAY = 2'd3
    } state_t;

    // One load or store access as seen by the cache pipeline.
    typedef struct packed {
        logic              is_load;
        logic              is_byte;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } access_t;

    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(4 * line_words);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned wsel_bits(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Load/store request side and memory line side of the data cache.
interface dcache_wb_if import dcache_wb_pkg::*; #(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
);
    localparam int unsigned LW = DATA_W * LINE_WORDS;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_is_byte;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_is_byte;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              dc_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LW-1:0]     mem_wdata;
    logic [LW-1:0]     mem_rdata;
    logic              mem_ack;

    modport slave (
        input  st_valid, st_addr, st_data, st_is_byte,
        input  ld_valid, ld_addr, ld_is_byte,
        input  mem_rdata, mem_ack,
        output ld_data, ld_done, dc_ready,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output st_valid, st_addr, st_data, st_is_byte,
        output ld_valid, ld_addr, ld_is_byte,
        output mem_rdata, mem_ack,
        input  ld_data, ld_done, dc_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous word/byte merge or full-line fill.
module dcache_line_array #(
    parameter int unsigned LINES = 4,
    parameter int unsigned LW    = 128,
    parameter int unsigned IDX_W = 2,
    parameter int unsigned TAG_W = 26,
    parameter int unsigned WS_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    output logic             rd_valid_c,
    output logic             rd_dirty_c,
    output logic [TAG_W-1:0] rd_tag_c,
    output logic [LW-1:0]    rd_line_c,
    input  logic             wr_en,
    input  logic             wr_byte,
    input  logic [WS_W-1:0]  wr_wsel,
    input  logic [1:0]       wr_bsel,
    input  logic [31:0]      wr_data,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [LW-1:0]    fill_line
);

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag  [LINES];
    logic [LW-1:0]    data [LINES];

    assign rd_valid_c = valid[idx];
    assign rd_dirty_c = dirty[idx];
    assign rd_tag_c   = tag[idx];
    assign rd_line_c  = data[idx];

    // Reset invalidates every line; a fill always lands clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data[idx] <= fill_line;
            tag[idx]  <= fill_tag;
        end else if (wr_en) begin
            if (wr_byte)
                data[idx][{wr_wsel, wr_bsel, 3'b000} +: 8] <= wr_data[7:0];
            else
                data[idx][{wr_wsel, 5'b00000} +: 32] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache behind the store buffer.
module dcache_wb import dcache_wb_pkg::*; #(
    parameter int unsigned LINES      = DEF_LINES,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input logic        clk,
    input logic        reset,
    dcache_wb_if.slave bus
);

    localparam int unsigned LW    = DATA_W * LINE_WORDS;
    localparam int unsigned OFF_W = off_bits(LINE_WORDS);
    localparam int unsigned IDX_W = idx_bits(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WS_W  = wsel_bits(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(4 * LINE_WORDS - 1);

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF_W + IDX_W));
    endfunction

    function automatic logic [WS_W-1:0] wsel_of(input logic [ADDR_W-1:0] a);
        return WS_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    state_t            state, state_n;
    access_t           req, req_n;
    access_t           pend, pend_n;
    logic              pend_v, pend_v_n;
    access_t           act, st_acc;
    logic              act_v, both, hit;

    logic [DATA_W-1:0] ld_data_r, ld_data_n;
    logic              ld_done_r, ld_done_n;
    logic              dc_ready_r, dc_ready_n;
    logic              mem_req_r, mem_req_n;
    logic              mem_we_r, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_n;
    logic [LW-1:0]     mem_wdata_r, mem_wdata_n;

    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LW-1:0]     rd_line;
    logic              wr_en, fill_en;
    logic [DATA_W-1:0] rd_word, load_val;

    assign st_acc = '{is_load: 1'b0, is_byte: bus.st_is_byte,
                      addr: bus.st_addr, data: bus.st_data};

    // Pick the access that touches the array this cycle (pending store wins in IDLE).
    always_comb begin
        act   = req;
        act_v = 1'b0;
        both  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_v) begin
                    act   = pend;
                    act_v = 1'b1;
                end else if (dc_ready_r && bus.ld_valid) begin
                    act   = '{is_load: 1'b1, is_byte: bus.ld_is_byte,
                              addr: bus.ld_addr, data: '0};
                    act_v = 1'b1;
                    both  = bus.st_valid;
                end else if (dc_ready_r && bus.st_valid) begin
                    act   = st_acc;
                    act_v = 1'b1;
                end
            end
            ST_REPLAY: act_v = 1'b1;
            default: ;
        endcase
    end

    dcache_line_array #(
        .LINES (LINES),
        .LW    (LW),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .WS_W  (WS_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .idx        (idx_of(act.addr)),
        .rd_valid_c (rd_valid),
        .rd_dirty_c (rd_dirty),
        .rd_tag_c   (rd_tag),
        .rd_line_c  (rd_line),
        .wr_en      (wr_en),
        .wr_byte    (act.is_byte),
        .wr_wsel    (wsel_of(act.addr)),
        .wr_bsel    (act.addr[1:0]),
        .wr_data    (act.data),
        .fill_en    (fill_en),
        .fill_tag   (tag_of(req.addr)),
        .fill_line  (bus.mem_rdata)
    );

    assign rd_word  = rd_line[{wsel_of(act.addr), 5'b00000} +: DATA_W];
    assign load_val = act.is_byte ? DATA_W'(rd_word[{act.addr[1:0], 3'b000} +: 8]) : rd_word;

    always_comb begin
        state_n     = state;
        req_n       = req;
        pend_n      = pend;
        pend_v_n    = pend_v;
        ld_data_n   = ld_data_r;
        ld_done_n   = 1'b0;
        mem_req_n   = 1'b0;
        mem_we_n    = mem_we_r;
        mem_addr_n  = mem_addr_r;
        mem_wdata_n = mem_wdata_r;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        hit         = rd_valid && (rd_tag == tag_of(act.addr));

        if (state == ST_IDLE && pend_v)
            pend_v_n = 1'b0;
        if (both) begin
            pend_v_n = 1'b1;
            pend_n   = st_acc;
        end

        // Memory handshake: request drops on the edge that sees the ack.
        case (state)
            ST_EVICT: begin
                if (mem_req_r && bus.mem_ack) begin
                    state_n = ST_FILL;
                end else begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = {rd_tag, idx_of(req.addr), OFF_W'(0)};
                    mem_wdata_n = rd_line;
                end
            end
            ST_FILL: begin
                if (mem_req_r && bus.mem_ack) begin
                    fill_en = 1'b1;
                    state_n = ST_REPLAY;
                end else begin
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = req.addr & ~OFF_MASK;
                end
            end
            default: ;
        endcase

        if (act_v) begin
            if (hit) begin
                state_n = ST_IDLE;
                if (act.is_load) begin
                    ld_done_n = 1'b1;
                    ld_data_n = load_val;
                end else begin
                    wr_en = 1'b1;
                end
            end else begin
                req_n   = act;
                state_n = (rd_valid && rd_dirty) ? ST_EVICT : ST_FILL;
            end
        end

        dc_ready_n = (state_n == ST_IDLE) && !pend_v_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend_v      <= 1'b0;
            ld_data_r   <= '0;
            ld_done_r   <= 1'b0;
            dc_ready_r  <= 1'b1;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            state       <= state_n;
            pend_v      <= pend_v_n;
            ld_data_r   <= ld_data_n;
            ld_done_r   <= ld_done_n;
            dc_ready_r  <= dc_ready_n;
            mem_req_r   <= mem_req_n;
            mem_we_r    <= mem_we_n;
            mem_addr_r  <= mem_addr_n;
            mem_wdata_r <= mem_wdata_n;
        end
    end

    // Payload registers are qualified by state/pend_v, so they need no reset.
    always_ff @(posedge clk) begin
        req  <= req_n;
        pend <= pend_n;
    end

    assign bus.ld_data   = ld_data_r;
    assign bus.ld_done   = ld_done_r;
    assign bus.dc_ready  = dc_ready_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a small line-memory responder (ack on the 2nd cycle of mem_req).
module tb_dcache_wb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_wb_if #(.LINE_WORDS(4)) bus ();

    dcache_wb #(.LINES(4), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: written-back lines override the default fill pattern.
    logic         hold   = 1'b0;
    logic         inject = 1'b0;
    logic [127:0] wb_mem   [64];
    logic         wb_valid [64];
    int           cnt   = 0;
    int           n_req = 0;
    logic [31:0]  log_addr  [8];
    logic         log_we    [8];
    logic [127:0] log_wdata [8];

    function automatic logic [127:0] line_pat(input logic [31:0] a);
        case (a)
            32'h100: return 128'h33333333_22222222_11111111_DEADBEEF;
            32'h140: return 128'h77777777_66666666_55555555_CAFEF00D;
            32'h1D0: return 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_89ABCDEF;
            default: return {4{a}};
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset || hold) begin
            cnt = 0;
            bus.mem_ack = inject;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            cnt = 0;
        end else if (bus.mem_req) begin
            cnt++;
            if (cnt == 2) begin
                cnt = 0;
                bus.mem_ack = 1'b1;
                if (n_req < 8) begin
                    log_addr[n_req]  = bus.mem_addr;
                    log_we[n_req]    = bus.mem_we;
                    log_wdata[n_req] = bus.mem_wdata;
                end
                n_req++;
                if (bus.mem_we) begin
                    wb_mem[bus.mem_addr[9:4]]   = bus.mem_wdata;
                    wb_valid[bus.mem_addr[9:4]] = 1'b1;
                end else if (wb_valid[bus.mem_addr[9:4]] === 1'b1) begin
                    bus.mem_rdata = wb_mem[bus.mem_addr[9:4]];
                end else begin
                    bus.mem_rdata = line_pat(bus.mem_addr);
                end
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic do_load(input logic [31:0] a, input logic b,
                           output logic [31:0] d, output int lat, output logic rdy1);
        bus.ld_valid   = 1'b1;
        bus.ld_addr    = a;
        bus.ld_is_byte = b;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        rdy1 = bus.dc_ready;
        lat  = 1;
        while (!bus.ld_done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.ld_done) check("ld_done_timeout", 128'(bus.ld_done), 128'(1'b1));
        d = bus.ld_data;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] v, input logic b);
        bus.st_valid   = 1'b1;
        bus.st_addr    = a;
        bus.st_data    = v;
        bus.st_is_byte = b;
        @(negedge clk);
        bus.st_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          n0;
        logic        rdy1;
        logic        seen;

        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_is_byte = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_is_byte = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ld_data",   128'(bus.ld_data),   128'(0));
        check("rst_ld_done",   128'(bus.ld_done),   128'(0));
        check("rst_dc_ready",  128'(bus.dc_ready),  128'(1));
        check("rst_mem_req",   128'(bus.mem_req),   128'(0));
        check("rst_mem_we",    128'(bus.mem_we),    128'(0));
        check("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
        check("rst_mem_wdata", bus.mem_wdata,       128'(0));

        // Cold load: one refill, ld_done five cycles after acceptance
        n0 = n_req;
        do_load(32'h100, 1'b0, d, lat, rdy1);
        check("cold_rdy",  128'(rdy1), 128'(0));
        check("cold_lat",  128'(lat), 128'(5));
        check("cold_data", 128'(d), 128'(32'hDEADBEEF));
        check("cold_nreq", 128'(n_req - n0), 128'(1));
        check("cold_addr", 128'(log_addr[n0]), 128'(32'h100));
        check("cold_we",   128'(log_we[n0]), 128'(0));

        // Byte store then word load on the resident line
        n0 = n_req;
        do_store(32'h101, 32'h000000AB, 1'b1);
        do_load(32'h100, 1'b0, d, lat, rdy1);
        check("bst_lat",  128'(lat), 128'(1));
        check("bst_data", 128'(d), 128'(32'hDEADABEF));
        check("bst_nreq", 128'(n_req - n0), 128'(0));

        // Dirty conflict: write-back of 0x100 then refill of 0x140
        n0 = n_req;
        do_load(32'h140, 1'b0, d, lat, rdy1);
        check("dirty_lat",   128'(lat), 128'(8));
        check("dirty_data",  128'(d), 128'(32'hCAFEF00D));
        check("dirty_nreq",  128'(n_req - n0), 128'(2));
        check("wb_addr",     128'(log_addr[n0]), 128'(32'h100));
        check("wb_we",       128'(log_we[n0]), 128'(1));
        check("wb_data",     log_wdata[n0], 128'h33333333_22222222_11111111_DEADABEF);
        check("refill_addr", 128'(log_addr[n0+1]), 128'(32'h140));
        check("refill_we",   128'(log_we[n0+1]), 128'(0));

        // Reload 0x100 (clean victim): sees the written-back data
        do_load(32'h100, 1'b0, d, lat, rdy1);
        check("reload_lat",  128'(lat), 128'(5));
        check("reload_data", 128'(d), 128'(32'hDEADABEF));

        // Simultaneous load and store
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h100; bus.ld_is_byte = 1'b0;
        bus.st_valid = 1'b1; bus.st_addr = 32'h104; bus.st_data = 32'h55; bus.st_is_byte = 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.st_valid = 1'b0;
        check("sim_done", 128'(bus.ld_done), 128'(1));
        check("sim_data", 128'(bus.ld_data), 128'(32'hDEADABEF));
        check("sim_rdy",  128'(bus.dc_ready), 128'(0));
        @(negedge clk);
        check("sim_rdy2", 128'(bus.dc_ready), 128'(1));
        do_load(32'h104, 1'b0, d, lat, rdy1);
        check("sim_st_lat",  128'(lat), 128'(1));
        check("sim_st_data", 128'(d), 128'(32'h55));

        // Drain burst of four word stores to the resident line
        n0 = n_req;
        for (int i = 0; i < 4; i++) begin
            check("burst_rdy", 128'(bus.dc_ready), 128'(1));
            bus.st_valid   = 1'b1;
            bus.st_addr    = 32'h100 + 32'(4 * i);
            bus.st_data    = 32'hA0 + 32'(i);
            bus.st_is_byte = 1'b0;
            @(negedge clk);
        end
        bus.st_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_load(32'h100 + 32'(4 * i), 1'b0, d, lat, rdy1);
            check("burst_lat",  128'(lat), 128'(1));
            check("burst_data", 128'(d), 128'(32'hA0 + 32'(i)));
        end
        check("burst_nreq", 128'(n_req - n0), 128'(0));

        // Reset while FILL holds mem_req high
        hold = 1'b1;
        @(negedge clk);
        n0 = n_req;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h1D0; bus.ld_is_byte = 1'b0;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
        check("rf_req",  128'(bus.mem_req), 128'(1));
        check("rf_we",   128'(bus.mem_we), 128'(0));
        check("rf_addr", 128'(bus.mem_addr), 128'(32'h1D0));
        reset = 1'b1;
        @(negedge clk);
        check("rf_req_drop", 128'(bus.mem_req), 128'(0));
        reset = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        seen |= bus.ld_done;
        inject = 1'b1;
        @(negedge clk);
        seen |= bus.ld_done;
        inject = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= bus.ld_done | bus.mem_req;
        end
        check("rf_no_done", 128'(seen), 128'(0));
        check("rf_ready",   128'(bus.dc_ready), 128'(1));
        hold = 1'b0;
        @(negedge clk);
        do_load(32'h1D0, 1'b0, d, lat, rdy1);
        check("rf_miss_lat",  128'(lat), 128'(5));
        check("rf_miss_data", 128'(d), 128'(32'h89ABCDEF));
        check("rf_miss_nreq", 128'(n_req - n0), 128'(1));
        do_load(32'h1D3, 1'b1, d, lat, rdy1);
        check("byte_ld_lat",  128'(lat), 128'(1));
        check("byte_ld_data", 128'(d), 128'(32'h89));
        do_load(32'h100, 1'b0, d, lat, rdy1);
        check("inval_lat",  128'(lat), 128'(5));
        check("inval_data", 128'(d), 128'(32'hDEADABEF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
